// File: rtl/wb_pkg.sv
// Shared types for the writeback slice: buffer depth default, load-size
// encoding, buffered entry layout and the load-extension helper.
// No ports; imported by wb_fifo and writeback_unit.
package wb_pkg;

  localparam int WB_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    LD_B = 2'd0,
    LD_H = 2'd1,
    LD_W = 2'd2,
    LD_D = 2'd3
  } ld_size_e;

  typedef struct packed {
    logic [4:0]  rd;
    logic        wen;
    logic [63:0] data;
  } wb_entry_t;

  // Narrow loads arrive LSB-aligned; widen to 64 bits here so the buffer
  // only ever holds final register values. Doublewords ignore the unsigned flag.
  function automatic logic [63:0] ld_extend(input logic [63:0] raw,
                                            input ld_size_e    size,
                                            input logic        is_unsigned);
    logic [63:0] r;
    r = raw;
    case (size)
      LD_B:    r = {{56{raw[7]  & ~is_unsigned}}, raw[7:0]};
      LD_H:    r = {{48{raw[15] & ~is_unsigned}}, raw[15:0]};
      LD_W:    r = {{32{raw[31] & ~is_unsigned}}, raw[31:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Result buffer: two enqueue slots per cycle (slot 0 written first), one dequeue.
// Latency: entry visible at head the cycle after it is written.
// Backpressure: none internally; the caller gates writes against DEPTH - count.
// Ports: clk/reset, wr0_en/wr0_entry, wr1_en/wr1_entry (only with wr0_en),
//        rd_en, head (oldest entry), count (registered occupancy).
module wb_fifo
  import wb_pkg::*;
#(
  parameter  int DEPTH = WB_DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr0_en,
  input  wb_entry_t     wr0_entry,
  input  logic          wr1_en,
  input  wb_entry_t     wr1_entry,
  input  logic          rd_en,
  output wb_entry_t     head,
  output logic [CW-1:0] count
);

  wb_entry_t         mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  // Storage is never reset: count/pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (wr0_en) mem[wr_ptr] <= wr0_entry;
    if (wr1_en) mem[wr_ptr + AW'(1)] <= wr1_entry;
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr0_en) + AW'(wr1_en);
      rd_ptr <= rd_ptr + AW'(rd_en);
      count  <= count + CW'(wr0_en) + CW'(wr1_en) - CW'(rd_en);
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/writeback_unit.sv
// Merges ALU and load results into an in-order buffer feeding one regfile write port.
// Latency: result enqueued into an empty buffer is written one cycle later.
// Backpressure: readies come from registered free space only; load has priority.
// Ports: clk/reset; ALU offer (i_alu_*, o_alu_ready); load offer (i_ld_*, o_ld_ready);
//        regfile write (o_wb_write_*); o_wb_empty; o_retire_count.
module writeback_unit
  import wb_pkg::*;
#(
  parameter int WB_DEPTH = WB_DEPTH_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_alu_valid,
  input  logic [4:0]  i_alu_rd,
  input  logic        i_alu_wen,
  input  logic [63:0] i_alu_data,
  output logic        o_alu_ready,
  input  logic        i_ld_valid,
  input  logic [4:0]  i_ld_rd,
  input  logic [63:0] i_ld_data,
  input  logic [1:0]  i_ld_size,
  input  logic        i_ld_unsigned,
  output logic        o_ld_ready,
  output logic        o_wb_write_the_register,
  output logic [4:0]  o_wb_write_reg_num,
  output logic [63:0] o_wb_write_data,
  output logic        o_wb_empty,
  output logic [31:0] o_retire_count
);

  localparam int CW = $clog2(WB_DEPTH) + 1;

  logic [CW-1:0] count;
  logic [CW-1:0] free;
  logic          ld_xfer;
  logic          alu_xfer;
  logic          deq;
  wb_entry_t     ld_entry;
  wb_entry_t     alu_entry;
  wb_entry_t     wr0_entry;
  wb_entry_t     head;

  // A dequeue in the same cycle does not free a slot for this cycle's offers.
  assign free        = CW'(WB_DEPTH) - count;
  assign o_ld_ready  = (free != '0);
  // The load takes the first free slot, so the ALU needs a second one if a load is offered.
  assign o_alu_ready = (free >= CW'(2)) || ((free != '0) && !i_ld_valid);

  assign ld_xfer  = i_ld_valid  && o_ld_ready;
  assign alu_xfer = i_alu_valid && o_alu_ready;
  assign deq      = (count != '0);

  always_comb begin
    ld_entry      = '0;
    ld_entry.rd   = i_ld_rd;
    ld_entry.wen  = 1'b1;
    ld_entry.data = ld_extend(i_ld_data, ld_size_e'(i_ld_size), i_ld_unsigned);

    alu_entry      = '0;
    alu_entry.rd   = i_alu_rd;
    alu_entry.wen  = i_alu_wen;
    alu_entry.data = i_alu_data;

    // Slot 0 is older than slot 1, so a load offered alongside an ALU result retires first.
    wr0_entry = ld_xfer ? ld_entry : alu_entry;
  end

  wb_fifo #(.DEPTH(WB_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .wr0_en    (ld_xfer | alu_xfer),
    .wr0_entry (wr0_entry),
    .wr1_en    (ld_xfer & alu_xfer),
    .wr1_entry (alu_entry),
    .rd_en     (deq),
    .head      (head),
    .count     (count)
  );

  assign o_wb_empty = (count == '0);

  // x0 is hardwired: such entries still retire but never raise the write strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_wb_write_the_register <= 1'b0;
      o_wb_write_reg_num      <= '0;
      o_wb_write_data         <= '0;
      o_retire_count          <= '0;
    end else if (deq) begin
      o_wb_write_the_register <= head.wen && (head.rd != 5'd0);
      o_wb_write_reg_num      <= head.rd;
      o_wb_write_data         <= head.data;
      o_retire_count          <= o_retire_count + 32'd1;
    end else begin
      o_wb_write_the_register <= 1'b0;
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_alu_valid, i_alu_wen, i_ld_valid, i_ld_unsigned;
  logic [4:0]  i_alu_rd, i_ld_rd;
  logic [63:0] i_alu_data, i_ld_data;
  logic [1:0]  i_ld_size;
  logic        o_alu_ready, o_ld_ready, o_wb_write_the_register, o_wb_empty;
  logic [4:0]  o_wb_write_reg_num;
  logic [63:0] o_wb_write_data;
  logic [31:0] o_retire_count;

  writeback_unit #(.WB_DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .i_alu_valid(i_alu_valid), .i_alu_rd(i_alu_rd), .i_alu_wen(i_alu_wen),
    .i_alu_data(i_alu_data), .o_alu_ready(o_alu_ready),
    .i_ld_valid(i_ld_valid), .i_ld_rd(i_ld_rd), .i_ld_data(i_ld_data),
    .i_ld_size(i_ld_size), .i_ld_unsigned(i_ld_unsigned), .o_ld_ready(o_ld_ready),
    .o_wb_write_the_register(o_wb_write_the_register),
    .o_wb_write_reg_num(o_wb_write_reg_num), .o_wb_write_data(o_wb_write_data),
    .o_wb_empty(o_wb_empty), .o_retire_count(o_retire_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [4:0]  rd;
    logic [63:0] data;
  } exp_t;

  typedef struct packed {
    logic        lv;
    logic [4:0]  lrd;
    logic [63:0] ldat;
    logic [1:0]  lsz;
    logic        lu;
    logic [63:0] lexp;
    logic        av;
    logic [4:0]  ard;
    logic        aw;
    logic [63:0] adat;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  exp_t        q[$];
  int          mcount   = 0;
  int unsigned mretire  = 0;
  exp_t        cur      = '0;
  vec_t        vt[12];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, " write_the_register"}, 64'(o_wb_write_the_register), 64'(cur.we));
    check({tag, " reg_num"}, 64'(o_wb_write_reg_num), 64'(cur.rd));
    check({tag, " data"}, o_wb_write_data, cur.data);
    check({tag, " retire_count"}, 64'(o_retire_count), 64'(mretire));
    check({tag, " empty"}, 64'(o_wb_empty), 64'(mcount == 0));
  endtask

  // One clock cycle: drive offers, check readies, push accepted results in
  // acceptance order, advance the model across the edge and compare outputs.
  task automatic step(input vec_t v);
    int   free, enq;
    logic mld, malu, deq;
    exp_t e;
    i_ld_valid = v.lv;  i_ld_rd = v.lrd;  i_ld_data = v.ldat;
    i_ld_size = v.lsz;  i_ld_unsigned = v.lu;
    i_alu_valid = v.av; i_alu_rd = v.ard; i_alu_wen = v.aw; i_alu_data = v.adat;
    #1;
    free = 4 - mcount;
    mld  = (free >= 1);
    malu = (free >= 2) || (free >= 1 && !v.lv);
    check("ld_ready", 64'(o_ld_ready), 64'(mld));
    check("alu_ready", 64'(o_alu_ready), 64'(malu));
    enq = 0;
    if (v.lv && mld) begin
      e.we = (v.lrd != 5'd0); e.rd = v.lrd; e.data = v.lexp;
      q.push_back(e); enq++;
    end
    if (v.av && malu) begin
      e.we = v.aw && (v.ard != 5'd0); e.rd = v.ard; e.data = v.adat;
      q.push_back(e); enq++;
    end
    @(posedge clk); #1;
    deq = (mcount > 0);
    if (deq) begin
      cur = q.pop_front();
      mretire++;
    end else begin
      cur.we = 1'b0;
    end
    mcount = mcount + enq - int'(deq);
    check_outputs("cycle");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step('0);
  endtask

  task automatic model_reset();
    q.delete();
    mcount  = 0;
    mretire = 0;
    cur     = '0;
  endtask

  initial begin
    vec_t v;
    // lv lrd ldat lsz lu lexp | av ard aw adat
    vt[0]  = '{1'b0, 5'd0, 64'd0, 2'd0, 1'b0, 64'd0, 1'b1, 5'd5, 1'b1, 64'h1234};
    vt[1]  = '{1'b1, 5'd1, 64'h80, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0, 5'd0, 1'b0, 64'd0};
    vt[2]  = '{1'b1, 5'd1, 64'h80, 2'd0, 1'b1, 64'h80, 1'b0, 5'd0, 1'b0, 64'd0};
    vt[3]  = '{1'b1, 5'd2, 64'h0000_0001_8000_0000, 2'd2, 1'b0, 64'hFFFF_FFFF_8000_0000, 1'b0, 5'd0, 1'b0, 64'd0};
    vt[4]  = '{1'b1, 5'd2, 64'h0000_0001_8000_0000, 2'd2, 1'b1, 64'h0000_0000_8000_0000, 1'b0, 5'd0, 1'b0, 64'd0};
    vt[5]  = '{1'b1, 5'd4, 64'h1234_8001, 2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_8001, 1'b0, 5'd0, 1'b0, 64'd0};
    vt[6]  = '{1'b1, 5'd4, 64'h1234_8001, 2'd1, 1'b1, 64'h8001, 1'b0, 5'd0, 1'b0, 64'd0};
    vt[7]  = '{1'b1, 5'd6, 64'h8000_0000_0000_0001, 2'd3, 1'b1, 64'h8000_0000_0000_0001, 1'b0, 5'd0, 1'b0, 64'd0};
    vt[8]  = '{1'b1, 5'd7, 64'h17F, 2'd0, 1'b0, 64'h7F, 1'b0, 5'd0, 1'b0, 64'd0};
    vt[9]  = '{1'b1, 5'd3, 64'hC3, 2'd3, 1'b0, 64'hC3, 1'b1, 5'd3, 1'b1, 64'hA1A1};
    vt[10] = '{1'b0, 5'd0, 64'd0, 2'd0, 1'b0, 64'd0, 1'b1, 5'd0, 1'b1, 64'hFF};
    vt[11] = '{1'b0, 5'd0, 64'd0, 2'd0, 1'b0, 64'd0, 1'b1, 5'd9, 1'b0, 64'h55};

    reset = 1'b1;
    i_alu_valid = 0; i_alu_rd = 0; i_alu_wen = 0; i_alu_data = 0;
    i_ld_valid = 0; i_ld_rd = 0; i_ld_data = 0; i_ld_size = 0; i_ld_unsigned = 0;
    @(posedge clk); @(posedge clk); #1;
    check_outputs("reset");
    #3 reset = 1'b0;
    @(posedge clk); #1;

    // Table: each vector followed by enough idle cycles to drain.
    for (int i = 0; i < 12; i++) begin
      step(vt[i]);
      idle(3);
    end
    check("retire after table", 64'(o_retire_count), 64'd13);

    // Fill with both producers valid every cycle; dequeue cannot be held off.
    v = '{1'b1, 5'd10, 64'hAAAA, 2'd3, 1'b0, 64'hAAAA, 1'b1, 5'd11, 1'b1, 64'hBBBB};
    step(v);
    v.ldat = 64'hAAAB; v.lexp = 64'hAAAB; v.adat = 64'hBBBC;
    step(v);
    i_ld_valid = 1'b1; i_alu_valid = 1'b1;
    #1;
    check("full3 alu_ready", 64'(o_alu_ready), 64'd0);
    check("full3 ld_ready", 64'(o_ld_ready), 64'd1);
    for (int i = 0; i < 5; i++) begin
      v.ldat = 64'hC000 + 64'(i); v.lexp = v.ldat; v.adat = 64'hD000 + 64'(i);
      step(v);
    end
    check("fill no empty", 64'(o_wb_empty), 64'd0);
    idle(6);
    check("fill drained", 64'(q.size()), 64'd0);

    // Reset with three entries buffered: outputs clear without waiting for a clock.
    v = '{1'b1, 5'd12, 64'h1111, 2'd3, 1'b0, 64'h1111, 1'b1, 5'd13, 1'b1, 64'h2222};
    step(v);
    v.ldat = 64'h3333; v.lexp = 64'h3333; v.adat = 64'h4444;
    step(v);
    check("pre-reset count3 alu_ready", 64'(o_alu_ready), 64'd0);
    i_ld_valid = 0; i_alu_valid = 0;
    #1 reset = 1'b1;
    #1;
    model_reset();
    check_outputs("async reset");
    #1 reset = 1'b0;
    @(posedge clk); #1;
    check_outputs("post reset");
    idle(5);
    check("no stale writes", 64'(o_retire_count), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion before 200000");
    $fatal(1);
  end

endmodule
